// File: rtl/hex_display.sv
// Four-digit multiplexed hex display driver: holds a captured 16-bit result and
// scans its nibbles onto active-low seven-segment outputs, with an optional leading-zero blank.
module hex_display #(
   parameter int REFRESH_DIV   = 50000,
   parameter int BLANK_LEADING = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] result,
   input  logic        result_valid,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx
);

   localparam int DIV = (REFRESH_DIV < 2) ? 2 : REFRESH_DIV;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic [15:0]   disp_q;
   logic [PW-1:0] presc_q;
   logic [1:0]    idx_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   logic          terminal;
   logic [1:0]    idx_next;
   logic [3:0]    nib;
   logic          blank;
   logic [6:0]    seg_d;
   logic [3:0]    an_d;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'h40;
         4'h1: hex_decode = 7'h79;
         4'h2: hex_decode = 7'h24;
         4'h3: hex_decode = 7'h30;
         4'h4: hex_decode = 7'h19;
         4'h5: hex_decode = 7'h12;
         4'h6: hex_decode = 7'h02;
         4'h7: hex_decode = 7'h78;
         4'h8: hex_decode = 7'h00;
         4'h9: hex_decode = 7'h10;
         4'hA: hex_decode = 7'h08;
         4'hB: hex_decode = 7'h03;
         4'hC: hex_decode = 7'h46;
         4'hD: hex_decode = 7'h21;
         4'hE: hex_decode = 7'h06;
         default: hex_decode = 7'h0E;
      endcase
   endfunction

   // Digit k is a leading zero when it and every more significant nibble are zero.
   function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
      case (k)
         2'd1:    lead_zero = (v[15:4] == 12'h000);
         2'd2:    lead_zero = (v[15:8] == 8'h00);
         2'd3:    lead_zero = (v[15:12] == 4'h0);
         default: lead_zero = 1'b0;
      endcase
   endfunction

   always_comb begin
      terminal = (presc_q == PRESC_LAST);
      idx_next = terminal ? idx_q + 2'd1 : idx_q;
      nib      = disp_q[4*idx_next +: 4];
      blank    = (BLANK_LEADING != 0) && lead_zero(disp_q, idx_next);
      seg_d    = blank ? 7'h7F : hex_decode(nib);
      // The terminal edge blanks all anodes for one cycle to avoid ghosting across digits.
      an_d     = terminal ? 4'b1111 : ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q  <= 16'h0000;
         presc_q <= '0;
         idx_q   <= 2'd0;
         an_q    <= 4'b1111;
         seg_q   <= 7'h7F;
      end else begin
         if (result_valid)
            disp_q <= result;
         presc_q <= terminal ? '0 : presc_q + 1'b1;
         idx_q   <= idx_next;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_hex_display.sv
// Scoreboard bench for hex_display: two instances (blanking off/on) share stimulus and
// are compared each cycle against a cycle-count model of the scan.
module tb_hex_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] result = 16'h0000;
   logic        result_valid = 1'b0;
   logic [6:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic [1:0]  idx0, idx1;

   hex_display #(.REFRESH_DIV(4), .BLANK_LEADING(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid),
      .seg(seg0), .an(an0), .digit_idx(idx0));

   hex_display #(.REFRESH_DIV(4), .BLANK_LEADING(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid),
      .seg(seg1), .an(an1), .digit_idx(idx1));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg0;
      logic [6:0] seg1;
      logic [1:0] idx;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          m_n = 0;
   logic [15:0] m_disp = 16'h0000;
   logic [6:0]  dec_tab [16];

   function automatic logic [6:0] model_seg(input logic [15:0] d, input int k, input bit bl);
      logic [15:0] upper;
      upper = d >> (4 * k);
      if (bl && k != 0 && upper == 16'h0000)
         return 7'h7F;
      return dec_tab[upper[3:0]];
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, compare after the edge.
   task automatic cycle(input logic rv, input logic [15:0] res);
      exp_t e;
      int   ib, ia;
      result_valid = rv;
      result       = res;
      ib = (m_n / 4) % 4;
      ia = ((m_n + 1) / 4) % 4;
      e.an   = (m_n % 4 == 3) ? 4'b1111 : 4'(~(4'b0001 << ib));
      e.idx  = 2'(ia);
      e.seg0 = model_seg(m_disp, ia, 1'b0);
      e.seg1 = model_seg(m_disp, ia, 1'b1);
      sbq.push_back(e);
      if (rv) m_disp = res;
      m_n++;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_empty cycle=%0d", m_n);
      end else begin
         e = sbq.pop_front();
         checks++;
         if (an0 !== e.an) begin failures++; $display("FAIL an0 cycle=%0d got=%b want=%b", m_n, an0, e.an); end
         checks++;
         if (an1 !== e.an) begin failures++; $display("FAIL an1 cycle=%0d got=%b want=%b", m_n, an1, e.an); end
         checks++;
         if (idx0 !== e.idx || idx1 !== e.idx) begin
            failures++; $display("FAIL digit_idx cycle=%0d got=%0d/%0d want=%0d", m_n, idx0, idx1, e.idx);
         end
         checks++;
         if (seg0 !== e.seg0) begin failures++; $display("FAIL seg_noblank cycle=%0d got=%h want=%h", m_n, seg0, e.seg0); end
         checks++;
         if (seg1 !== e.seg1) begin failures++; $display("FAIL seg_blank cycle=%0d got=%h want=%h", m_n, seg1, e.seg1); end
      end
   endtask

   // Assert reset away from any clock edge, check the forced values, release at a negedge.
   task automatic do_reset(input string tag);
      #1;
      rst_n = 1'b0;
      result_valid = 1'b0;
      #1;
      checks++;
      if (an0 !== 4'b1111 || an1 !== 4'b1111) begin
         failures++; $display("FAIL %s_an got=%b/%b want=1111", tag, an0, an1);
      end
      checks++;
      if (seg0 !== 7'h7F || seg1 !== 7'h7F) begin
         failures++; $display("FAIL %s_seg got=%h/%h want=7f", tag, seg0, seg1);
      end
      checks++;
      if (idx0 !== 2'd0 || idx1 !== 2'd0) begin
         failures++; $display("FAIL %s_idx got=%0d/%0d want=0", tag, idx0, idx1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_n = 0;
      m_disp = 16'h0000;
   endtask

   task automatic test_reset();
      do_reset("reset");
      cycle(1'b0, 16'h0000);
      checks++;
      if (an0 !== 4'b1110 || seg0 !== 7'h40) begin
         failures++; $display("FAIL first_edge got an=%b seg=%h want an=1110 seg=40", an0, seg0);
      end
      for (int i = 0; i < 17; i++) cycle(1'b0, 16'h0000);
   endtask

   task automatic test_hex_pattern();
      logic [6:0] got [4];
      logic [6:0] want [4];
      logic [3:0] sel;
      want = '{7'h0E, 7'h30, 7'h08, 7'h79};
      for (int d = 0; d < 4; d++) got[d] = 7'h7F;
      cycle(1'b1, 16'h1A3F);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 16'h0000);
         for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            if (an0 === sel) got[d] = seg0;
         end
      end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (got[d] !== want[d]) begin
            failures++; $display("FAIL pattern_digit%0d got=%h want=%h", d, got[d], want[d]);
         end
      end
   endtask

   task automatic test_blanking();
      cycle(1'b1, 16'h0007);
      for (int i = 0; i < 17; i++) cycle(1'b0, 16'h0000);
      cycle(1'b1, 16'h0100);
      for (int i = 0; i < 17; i++) cycle(1'b0, 16'h0000);
   endtask

   task automatic test_terminal_capture();
      while ((m_n % 4) != 3) cycle(1'b0, 16'h0000);
      cycle(1'b1, 16'hFFFF);
      checks++;
      if (an0 !== 4'b1111) begin failures++; $display("FAIL term_blank got=%b want=1111", an0); end
      cycle(1'b0, 16'h0000);
      checks++;
      if (seg0 !== 7'h0E || seg1 !== 7'h0E) begin
         failures++; $display("FAIL term_capture got=%h/%h want=0e", seg0, seg1);
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000);
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 16'h0001);
      cycle(1'b1, 16'h0002);
      cycle(1'b1, 16'h0003);
      for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0000);
      checks++;
      if (u_dut0.disp_q !== 16'h0003) begin
         failures++; $display("FAIL b2b_disp got=%h want=0003", u_dut0.disp_q);
      end
   endtask

   task automatic test_reset_midscan();
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0000);
      cycle(1'b1, 16'hBEEF);
      cycle(1'b0, 16'h0000);
      do_reset("midscan");
      cycle(1'b1, 16'h0005);
      checks++;
      if (an0 !== 4'b1110 || seg0 !== 7'h40) begin
         failures++; $display("FAIL post_reset got an=%b seg=%h want an=1110 seg=40", an0, seg0);
      end
      for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000);
   endtask

   initial begin
      dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      test_reset();
      test_hex_pattern();
      test_blanking();
      test_terminal_capture();
      test_back_to_back();
      test_reset_midscan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex_display.md
HEX_DISPLAY -- requirements
Module: hex_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each digit is driven; values below 2 SHALL be treated as 2.
REQ-002 Parameter BLANK_LEADING, default 0: 1 enables leading-zero blanking.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 result  input  16  value to display, as produced by the processor stage.
REQ-006 result_valid  input  1  capture strobe; result SHALL be sampled on every rising edge where this is high.
REQ-007 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}, registered.
REQ-008 an  output  4  active-low digit enables, an[0] = least significant nibble, registered.
REQ-009 digit_idx  output  2  index of the digit currently being scanned.

Function
REQ-010 The block SHALL hold a 16-bit display register disp_q, loaded from result on each edge where result_valid=1 and otherwise held.
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the cycle at REFRESH_DIV-1 SHALL be the terminal cycle.
REQ-012 At the edge that ends a terminal cycle, digit_idx SHALL advance by 1 mod 4 (3 -> 0).
REQ-013 At that same edge, an SHALL load 4'b1111 (one-cycle anti-ghost blank), and seg SHALL load the decode of the nibble for the new digit_idx.
REQ-014 On every other edge, an SHALL load ~(4'b0001 << digit_idx), and seg SHALL load the decode of disp_q[4*digit_idx+3 : 4*digit_idx].
REQ-015 seg SHALL decode from disp_q as it was before the edge, so a capture reaches seg two edges after result_valid is sampled.
REQ-016 A capture SHALL NOT reset the prescaler or digit_idx.
REQ-017 Hex decode (active-low) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-018 With BLANK_LEADING=1, digit k (k=1..3) SHALL output seg=7'h7F when nibbles k..3 of disp_q are all zero. Digit 0 SHALL never be blanked.
REQ-019 With BLANK_LEADING=0, no digit SHALL be blanked apart from the REQ-013 anti-ghost cycle.
REQ-020 When result_valid coincides with a terminal cycle, both actions SHALL occur at the same edge, with no priority between them.
REQ-021 The prescaler SHALL be wide enough for REFRESH_DIV-1 and SHALL never exceed it.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force disp_q=0, prescaler=0, digit_idx=0, an=4'b1111 and seg=7'h7F, independent of clk.
REQ-023 Reset asserted mid-scan or mid-blank SHALL abandon that state entirely.
REQ-024 After rst_n rises, the first edge SHALL be a normal (non-terminal) cycle: an=4'b1110 and seg=7'h40.
REQ-025 A result_valid on the first edge after release SHALL be captured.

Verification (REFRESH_DIV=4)
REQ-026 Reset then idle -> the cycle after release gives an=1110, seg=40. Digit advances every 4 cycles with one an=1111 cycle, sequence 1110,1101,1011,0111, then wraps to 1110.
REQ-027 result=16'h1A3F with a single-cycle result_valid -> over one full scan, seg per digit is 0E,30,08,79 (digits 0..3).
REQ-028 BLANK_LEADING=1, result=16'h0007 -> digit 0 shows 78, digits 1..3 show 7F. Then result=16'h0100 -> digits 0..2 show 40,40,79 and digit 3 shows 7F.
REQ-029 result_valid in the terminal cycle with result=16'hFFFF -> digit_idx advances normally, and the new digit shows 0E from the following edge onward.
REQ-030 rst_n pulled low mid-digit with no clk edge -> an=1111, seg=7F immediately. After release the scan restarts at digit 0 with disp_q=0.
REQ-031 result_valid held high for 3 cycles with values 1,2,3 -> disp_q ends at 3, with no prescaler disturbance (digit change still occurs every 4 cycles).
